imem_arbiter: RTL and testbench

Arbiter and sequencer for the single instruction-memory port of the RV32I core. It shares the memory between the core's fetch path (reads) and the program loader (writes). After reset it holds the core stalled while the loader fills memory, then gives fetch priority while still servicing late loader writes. It registers fetch responses, flags illegal fetch and load addresses, and counts loaded words.

---
 rtl/imem_arbiter.sv | 142 ++++++++++++++
 tb/tb_imem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single instruction-memory port between the core
// fetch path (reads) and the program loader (writes).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   fetch_req_i/fetch_addr_i         fetch request and byte address
//   fetch_gnt_o                      fetch accepted (combinational)
//   fetch_valid_o/_instr_o/_err_o    registered fetch response
//   load_req_i/_addr_i/_data_i       loader write request
//   load_gnt_o                       load accepted (combinational)
//   load_err_o                       pulse: previous granted load was dropped
//   load_count_o                     saturating count of committed loads
//   boot_done_i                      loader finished pulse (BOOT -> RUN)
//   core_stall_o                     core must hold its PC
//   state_o                          0 BOOT, 1 RUN
//   mem_addr_o/_we_o/_wdata_o        memory port, mem_rdata_i combinational read data
module imem_arbiter #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_gnt_o,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic        fetch_err_o,
    input  logic        load_req_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i,
    output logic        load_gnt_o,
    output logic        load_err_o,
    output logic [15:0] load_count_o,
    input  logic        boot_done_i,
    output logic        core_stall_o,
    output logic [1:0]  state_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned STARVE_W  = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                load_forced;
    logic                fetch_legal;
    logic                load_legal;

    // Word-aligned and inside the memory.
    function automatic logic addr_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));
    endfunction

    assign fetch_legal = addr_legal(fetch_addr_i);
    assign load_legal  = addr_legal(load_addr_i);
    assign state_o     = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: BOOT leaves on boot_done_i; RUN is left only by reset.
    always_comb begin
        state_nxt = state;
        if ((state == ST_BOOT) && boot_done_i) begin
            state_nxt = ST_RUN;
        end
    end

    // Grants, stall and memory port mux.
    always_comb begin
        fetch_gnt_o  = 1'b0;
        load_gnt_o   = 1'b0;
        core_stall_o = 1'b1;
        load_forced  = 1'b0;
        mem_addr_o   = 32'h0;
        mem_wdata_o  = 32'h0;
        mem_we_o     = 1'b0;
        if (!rst) begin
            if (state == ST_BOOT) begin
                load_gnt_o = load_req_i;
            end else begin
                // A load refused STARVE_MAX times in a row overrides fetch priority.
                load_forced  = load_req_i && (starve_cnt == STARVE_W'(STARVE_MAX));
                load_gnt_o   = load_req_i && (!fetch_req_i || load_forced);
                fetch_gnt_o  = fetch_req_i && !load_forced;
                core_stall_o = (fetch_req_i && !fetch_gnt_o) || load_forced;
            end
        end
        if (load_gnt_o) begin
            mem_addr_o  = load_addr_i;
            mem_wdata_o = load_data_i;
            mem_we_o    = load_legal;
        end else if (fetch_gnt_o) begin
            mem_addr_o = fetch_addr_i;
        end
    end

    // Fetch response capture, load bookkeeping and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid_o <= 1'b0;
            fetch_instr_o <= NOP_INSTR;
            fetch_err_o   <= 1'b0;
            load_err_o    <= 1'b0;
            load_count_o  <= 16'h0;
            starve_cnt    <= '0;
        end else begin
            fetch_valid_o <= fetch_gnt_o;
            if (fetch_gnt_o) begin
                fetch_instr_o <= fetch_legal ? mem_rdata_i : NOP_INSTR;
                fetch_err_o   <= !fetch_legal;
            end
            load_err_o <= load_gnt_o && !load_legal;
            if (load_gnt_o && load_legal && (load_count_o != 16'hFFFF)) begin
                load_count_o <= load_count_o + 16'd1;
            end
            if ((state == ST_RUN) && load_req_i && !load_gnt_o) begin
                if (starve_cnt < STARVE_W'(STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + STARVE_W'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: a stimulus process drives one cycle at a time and
// predicts grants/outputs with a spec-level model; expected fetch responses
// are queued and checked by an independent monitor.
module tb_imem_arbiter;

    localparam int unsigned DEPTH      = 1024;
    localparam int unsigned STARVE_MAX = 4;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_gnt_o;
    logic        fetch_valid_o;
    logic [31:0] fetch_instr_o;
    logic        fetch_err_o;
    logic        load_req_i;
    logic [31:0] load_addr_i;
    logic [31:0] load_data_i;
    logic        load_gnt_o;
    logic        load_err_o;
    logic [15:0] load_count_o;
    logic        boot_done_i;
    logic        core_stall_o;
    logic [1:0]  state_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    imem_arbiter #(.DEPTH_WORDS(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_gnt_o(fetch_gnt_o),
        .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o), .fetch_err_o(fetch_err_o),
        .load_req_i(load_req_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
        .load_gnt_o(load_gnt_o), .load_err_o(load_err_o), .load_count_o(load_count_o),
        .boot_done_i(boot_done_i), .core_stall_o(core_stall_o), .state_o(state_o),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Environment memory attached to the DUT port.
    logic [31:0] bmem [DEPTH];
    assign mem_rdata_i = bmem[mem_addr_o[11:2]];
    always @(posedge clk) begin
        if (mem_we_o) bmem[mem_addr_o[11:2]] <= mem_wdata_o;
    end

    // Reference model state.
    logic [31:0] m_mem [DEPTH];
    bit          m_run;
    int          m_starve;
    int          m_count;
    bit          m_lerr;

    typedef struct packed { logic [31:0] instr; logic err; } resp_t;
    resp_t exp_q[$];

    int  checks   = 0;
    int  failures = 0;
    bit  mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'(4 * DEPTH));
    endfunction

    // One clock cycle: check registered outputs, drive inputs, check
    // combinational outputs against the model, then advance the model.
    task automatic step(input bit r, input bit f, input logic [31:0] fa,
                        input bit l, input logic [31:0] la, input logic [31:0] ld,
                        input bit bd, output bit fg, output bit lg);
        bit efg, elg, estall, force_l;
        @(negedge clk);
        chk("state", 32'(state_o), 32'(m_run));
        chk("load_count", 32'(load_count_o), 32'(m_count));
        chk("load_err", 32'(load_err_o), 32'(m_lerr));
        rst = r; fetch_req_i = f; fetch_addr_i = fa;
        load_req_i = l; load_addr_i = la; load_data_i = ld; boot_done_i = bd;
        #1;
        force_l = 1'b0;
        if (r) begin
            efg = 0; elg = 0; estall = 1;
        end else if (!m_run) begin
            efg = 0; elg = l; estall = 1;
        end else begin
            force_l = l && (m_starve == STARVE_MAX);
            elg     = l && (!f || force_l);
            efg     = f && !force_l;
            estall  = (f && !efg) || force_l;
        end
        chk("fetch_gnt", 32'(fetch_gnt_o), 32'(efg));
        chk("load_gnt", 32'(load_gnt_o), 32'(elg));
        chk("core_stall", 32'(core_stall_o), 32'(estall));
        chk("mem_we", 32'(mem_we_o), 32'(elg && legal(la)));
        if (elg) chk("mem_addr_load", mem_addr_o, la);
        if (efg) begin
            if (legal(fa)) exp_q.push_back('{instr: m_mem[fa[11:2]], err: 1'b0});
            else           exp_q.push_back('{instr: NOP, err: 1'b1});
        end
        if (r) begin
            m_run = 0; m_starve = 0; m_count = 0; m_lerr = 0;
        end else begin
            if (elg && legal(la)) begin
                m_mem[la[11:2]] = ld;
                if (m_count < 16'hFFFF) m_count++;
            end
            m_lerr = elg && !legal(la);
            if (m_run && l && !elg) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            else                    m_starve = 0;
            if (!m_run && bd) m_run = 1;
        end
        fg = efg; lg = elg;
    endtask

    // Monitor: every presented response must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (fetch_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL fetch_valid unexpected actual=1 required=0 at %0t", $time);
                end else begin
                    resp_t e;
                    e = exp_q.pop_front();
                    chk("fetch_instr", fetch_instr_o, e.instr);
                    chk("fetch_err", 32'(fetch_err_o), 32'(e.err));
                end
            end else if (exp_q.size() != 0) begin
                checks++; failures++;
                $display("FAIL fetch_valid missing actual=%b required=1 at %0t", fetch_valid_o, $time);
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        k = $urandom % 16;
        if (k == 0) return 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
        if (k == 1) return 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
        return 32'(4 * $urandom_range(0, 63));
    endfunction

    initial begin
        bit fg, lg;
        bit pf, pl;
        logic [31:0] pfa, pla, pld;
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            bmem[i]  = 32'(i) * 32'h9E37_79B1;
            m_mem[i] = 32'(i) * 32'h9E37_79B1;
        end
        rst = 1; fetch_req_i = 0; fetch_addr_i = 0; load_req_i = 0;
        load_addr_i = 0; load_data_i = 0; boot_done_i = 0;
        m_run = 0; m_starve = 0; m_count = 0; m_lerr = 0;
        @(posedge clk);
        @(posedge clk);
        mon_en = 1'b1;

        // Reset, then boot loads with a stalled fetch alongside.
        step(1, 0, 0, 0, 0, 0, 0, fg, lg);
        step(0, 0, 0, 0, 0, 0, 0, fg, lg);
        chk("rst_instr", fetch_instr_o, NOP);
        chk("rst_err", 32'(fetch_err_o), 32'd0);
        chk("rst_valid", 32'(fetch_valid_o), 32'd0);
        step(0, 1, 0, 1, 32'h0, 32'h0050_0093, 0, fg, lg);
        step(0, 1, 0, 1, 32'h4, 32'h0010_0113, 0, fg, lg);

        // Boot done, then back-to-back fetches of the loaded words.
        step(0, 0, 0, 0, 0, 0, 1, fg, lg);
        chk("boot_count", 32'(load_count_o), 32'd2);
        step(0, 1, 32'h0, 0, 0, 0, 0, fg, lg);
        step(0, 1, 32'h4, 0, 0, 0, 0, fg, lg);
        chk("fetch0_instr", fetch_instr_o, 32'h0050_0093);
        step(0, 1, 32'h6, 0, 0, 0, 0, fg, lg);
        chk("fetch4_instr", fetch_instr_o, 32'h0010_0113);
        step(0, 1, 32'(4 * DEPTH), 0, 0, 0, 0, fg, lg);

        // Starvation: load forced through on its 5th requesting cycle.
        n = 0;
        do begin
            step(0, 1, 32'h0, 1, 32'h8, 32'hDEAD_BEEF, 0, fg, lg);
            n++;
        end while (!lg && n < 10);
        chk("starve_cycles", 32'(n), 32'(STARVE_MAX + 1));
        step(0, 1, 32'h8, 0, 0, 0, 0, fg, lg);
        step(0, 0, 0, 0, 0, 0, 0, fg, lg);
        chk("raw_instr", fetch_instr_o, 32'hDEAD_BEEF);

        // Illegal load is dropped.
        step(0, 0, 0, 1, 32'h3, 32'h1234_5678, 0, fg, lg);
        step(0, 0, 0, 0, 0, 0, 0, fg, lg);
        chk("illegal_load_err", 32'(load_err_o), 32'd1);

        // Random traffic with request hold until grant.
        pf = 0; pl = 0; pfa = 0; pla = 0; pld = 0;
        for (int c = 0; c < 3000; c++) begin
            bit r, bd;
            if (!pf && ($urandom % 4 != 0)) begin pf = 1; pfa = rand_addr(); end
            if (!pl && ($urandom % 5 == 0)) begin pl = 1; pla = rand_addr(); pld = $urandom; end
            r  = ($urandom % 400 == 0);
            bd = ($urandom % 20 == 0);
            step(r, pf, pfa, pl, pla, pld, bd, fg, lg);
            if (fg) pf = 0;
            if (lg) pl = 0;
        end

        // Reset one cycle after a fetch grant.
        step(0, 0, 0, 0, 0, 0, 1, fg, lg);
        step(0, 1, 32'h4, 0, 0, 0, 0, fg, lg);
        step(1, 0, 0, 0, 0, 0, 0, fg, lg);
        step(0, 0, 0, 0, 0, 0, 0, fg, lg);
        chk("midrst_valid", 32'(fetch_valid_o), 32'd0);
        chk("midrst_state", 32'(state_o), 32'd0);
        chk("midrst_count", 32'(load_count_o), 32'd0);
        chk("midrst_stall", 32'(core_stall_o), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, fg, lg);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
